// File: rtl/rom_arb_pkg.sv
// Shared definitions for the ROM access arbiter: widths, FSM state and requester ids.
package rom_arb_pkg;

    localparam int unsigned ARB_DATA_WIDTH = 16;
    localparam int unsigned ROM_WORD_WIDTH = 32;
    localparam int unsigned ROM_HALF_WIDTH = ROM_WORD_WIDTH / 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_id_e;

    // The requester that did not win last time.
    function automatic port_id_e other_port(input port_id_e p);
        return (p == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
    endfunction

endpackage

// File: rtl/rom_arb_pick.sv
// Grant selection between the fetch and data requesters (combinational).
//   fetch_req, data_req : pending requests
//   last_grant          : requester granted most recently (used only with ROM_ARB_RR_EN)
//   grant_c             : selected requester; meaningful only when a request is pending
// Build option: define ROM_ARB_RR_EN for round-robin on contention, otherwise data wins.
module rom_arb_pick
    import rom_arb_pkg::*;
(
    input  logic     fetch_req,
    input  logic     data_req,
    input  port_id_e last_grant,
    output port_id_e grant_c
);

`ifndef ROM_ARB_RR_EN
    // Fixed priority ignores history.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        grant_c = PORT_FETCH;
        if (fetch_req && data_req) begin
`ifdef ROM_ARB_RR_EN
            grant_c = other_port(last_grant);
`else
            grant_c = PORT_DATA;
`endif
        end else if (data_req) begin
            grant_c = PORT_DATA;
        end
    end

endmodule

// File: rtl/rom_access_arbiter.sv
// Arbitrates a single-port ROM between an instruction-fetch and a data-read requester.
// One transaction walks IDLE -> ISSUE -> CAPTURE -> RESP; a request seen in IDLE at
// edge N yields its ack pulse sampled at edge N+3.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   fetch_req/fetch_addr/fetch_ack  : fetch handshake; fetch_opcode/fetch_operand results
//   data_req/data_addr/data_ack     : data handshake; data_out result
//   rom_en/rom_addr/rom_rdata       : ROM read port, data valid the cycle after rom_en
//   busy                            : transaction in flight
//   addr_err                        : sticky, an address >= ROM_DEPTH was granted
// Build option: ROM_ARB_RR_EN selects round-robin arbitration on contention.
module rom_access_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH,
    parameter int unsigned ROM_DEPTH  = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fetch_req,
    input  logic [DATA_WIDTH-1:0]     fetch_addr,
    output logic                      fetch_ack,
    output logic [DATA_WIDTH-1:0]     fetch_opcode,
    output logic [DATA_WIDTH-1:0]     fetch_operand,
    input  logic                      data_req,
    input  logic [DATA_WIDTH-1:0]     data_addr,
    output logic                      data_ack,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      rom_en,
    output logic [DATA_WIDTH-1:0]     rom_addr,
    input  logic [ROM_WORD_WIDTH-1:0] rom_rdata,
    output logic                      busy,
    output logic                      addr_err
);

    arb_state_e            state;
    port_id_e              sel_port;
    logic                  sel_oor;
    port_id_e              last_grant;
    port_id_e              grant_c;
    logic [DATA_WIDTH-1:0] pick_addr_c;
    logic                  pick_oor_c;

    rom_arb_pick u_pick (
        .fetch_req  (fetch_req),
        .data_req   (data_req),
        .last_grant (last_grant),
        .grant_c    (grant_c)
    );

    // Address of the requester about to be granted and its range check.
    assign pick_addr_c = (grant_c == PORT_DATA) ? data_addr : fetch_addr;
    assign pick_oor_c  = 32'(pick_addr_c) >= 32'(ROM_DEPTH);

`ifdef ROM_ARB_RR_EN
    // History for round-robin; starts at fetch so the first contested grant goes to data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_FETCH;
        end else if (state == ST_IDLE && (fetch_req || data_req)) begin
            last_grant <= grant_c;
        end
    end
`else
    assign last_grant = PORT_FETCH;
`endif

    // Transaction FSM with registered outputs; rom_addr doubles as the granted address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            sel_port      <= PORT_FETCH;
            sel_oor       <= 1'b0;
            fetch_ack     <= 1'b0;
            data_ack      <= 1'b0;
            rom_en        <= 1'b0;
            busy          <= 1'b0;
            addr_err      <= 1'b0;
            fetch_opcode  <= '0;
            fetch_operand <= '0;
            data_out      <= '0;
            rom_addr      <= '0;
        end else begin
            fetch_ack <= 1'b0;
            data_ack  <= 1'b0;
            rom_en    <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (fetch_req || data_req) begin
                        state    <= ST_ISSUE;
                        busy     <= 1'b1;
                        sel_port <= grant_c;
                        sel_oor  <= pick_oor_c;
                        rom_addr <= pick_addr_c;
                        rom_en   <= !pick_oor_c;
                        if (pick_oor_c) begin
                            addr_err <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // A requester that withdrew gets neither results nor ack.
                    state <= ST_RESP;
                    if (sel_port == PORT_FETCH && fetch_req) begin
                        fetch_ack     <= 1'b1;
                        fetch_opcode  <= sel_oor ? '0
                                       : DATA_WIDTH'(rom_rdata[ROM_WORD_WIDTH-1:ROM_HALF_WIDTH]);
                        fetch_operand <= sel_oor ? '0
                                       : DATA_WIDTH'(rom_rdata[ROM_HALF_WIDTH-1:0]);
                    end else if (sel_port == PORT_DATA && data_req) begin
                        data_ack <= 1'b1;
                        data_out <= sel_oor ? '0
                                  : DATA_WIDTH'(rom_rdata[ROM_HALF_WIDTH-1:0]);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter with a registered ROM model.
module tb_rom_access_arbiter;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack;
    logic [15:0] fetch_opcode;
    logic [15:0] fetch_operand;
    logic        data_req;
    logic [15:0] data_addr;
    logic        data_ack;
    logic [15:0] data_out;
    logic        rom_en;
    logic [15:0] rom_addr;
    logic [31:0] rom_rdata;
    logic        busy;
    logic        addr_err;

    int total = 0;
    int bad   = 0;

    int d_at, f_at, k, lat, seen;
    int ack_cyc [4];
    int ack_dat [4];
    int exp_dat [4];

    rom_access_arbiter #(
        .DATA_WIDTH (16),
        .ROM_DEPTH  (256)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_ack     (fetch_ack),
        .fetch_opcode  (fetch_opcode),
        .fetch_operand (fetch_operand),
        .data_req      (data_req),
        .data_addr     (data_addr),
        .data_ack      (data_ack),
        .data_out      (data_out),
        .rom_en        (rom_en),
        .rom_addr      (rom_addr),
        .rom_rdata     (rom_rdata),
        .busy          (busy),
        .addr_err      (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: word 5 is 0x3102_00AB, others {a^A5A5, a+1000}.
    function automatic logic [31:0] rom_word(input logic [15:0] a);
        if (a == 16'h0005) return 32'h3102_00AB;
        return {a ^ 16'hA5A5, a + 16'h1000};
    endfunction

    // Registered ROM: data is valid only in the cycle after rom_en, garbage otherwise.
    always @(posedge clk) begin
        rom_rdata <= rom_en ? rom_word(rom_addr) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        data_req   = 1'b0;
        fetch_addr = '0;
        data_addr  = '0;
        step();
        step();
        chk("rst_busy",   32'(busy), 32'h0);
        chk("rst_rom_en", 32'(rom_en), 32'h0);
        chk("rst_fop",    32'(fetch_opcode), 32'h0);
        chk("rst_err",    32'(addr_err), 32'h0);
        rst_n = 1'b1;
        step();

        // Single fetch of word 5.
        fetch_addr = 16'h0005;
        fetch_req  = 1'b1;
        step();
        chk("t1_rom_en",  32'(rom_en), 32'h1);
        chk("t1_rom_addr", 32'(rom_addr), 32'h5);
        chk("t1_busy",    32'(busy), 32'h1);
        step();
        chk("t1_rom_en_off", 32'(rom_en), 32'h0);
        chk("t1_ack_early",  32'(fetch_ack), 32'h0);
        step();
        chk("t1_ack",     32'(fetch_ack), 32'h1);
        chk("t1_dack",    32'(data_ack), 32'h0);
        chk("t1_opcode",  32'(fetch_opcode), 32'h3102);
        chk("t1_operand", 32'(fetch_operand), 32'h00AB);
        fetch_req = 1'b0;
        step();
        chk("t1_ack_pulse", 32'(fetch_ack), 32'h0);
        chk("t1_hold",    32'(fetch_opcode), 32'h3102);
        chk("t1_idle",    32'(busy), 32'h0);

        // Contention: data wins first, fetch follows 4 cycles later.
        fetch_addr = 16'h0010;
        data_addr  = 16'h0020;
        fetch_req  = 1'b1;
        data_req   = 1'b1;
        d_at = -1;
        f_at = -1;
        for (int n = 1; n <= 20 && (d_at < 0 || f_at < 0); n++) begin
            step();
            chk("t2_excl", 32'(fetch_ack & data_ack), 32'h0);
            if (data_ack) begin
                d_at = n;
                chk("t2_dout", 32'(data_out), 32'h1020);
                data_req = 1'b0;
            end
            if (fetch_ack) begin
                f_at = n;
                chk("t2_opcode",  32'(fetch_opcode), 32'hA5B5);
                chk("t2_operand", 32'(fetch_operand), 32'h1010);
                fetch_req = 1'b0;
            end
        end
        chk("t2_data_cycle",  32'(d_at), 32'd3);
        chk("t2_fetch_cycle", 32'(f_at), 32'd7);
        fetch_req = 1'b0;
        data_req  = 1'b0;
        step();

        // Both held continuously: four acks at 4-cycle spacing.
`ifdef ROM_ARB_RR_EN
        exp_dat = '{1, 0, 1, 0};
`else
        exp_dat = '{1, 1, 1, 1};
`endif
        fetch_req = 1'b1;
        data_req  = 1'b1;
        k = 0;
        for (int n = 1; n <= 30 && k < 4; n++) begin
            step();
            chk("t3_excl", 32'(fetch_ack & data_ack), 32'h0);
            if (data_ack || fetch_ack) begin
                ack_cyc[k] = n;
                ack_dat[k] = data_ack ? 1 : 0;
                if (data_ack) chk("t3_dout", 32'(data_out), 32'h1020);
                else          chk("t3_opcode", 32'(fetch_opcode), 32'hA5B5);
                k++;
            end
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        chk("t3_count", 32'(k), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_order%0d", i), 32'(ack_dat[i]), 32'(exp_dat[i]));
            chk($sformatf("t3_cycle%0d", i), 32'(ack_cyc[i]), 32'(4 * i + 3));
        end
        step();
        step();
        chk("t3_idle", 32'(busy), 32'h0);

        // Out-of-range data address: no ROM access, zero result, sticky error.
        data_addr = 16'h0100;
        data_req  = 1'b1;
        lat  = -1;
        seen = 0;
        for (int n = 1; n <= 10 && lat < 0; n++) begin
            step();
            if (rom_en) seen = 1;
            if (data_ack) begin
                lat = n;
                chk("t4_dout", 32'(data_out), 32'h0);
                data_req = 1'b0;
            end
        end
        data_req = 1'b0;
        chk("t4_cycle",  32'(lat), 32'd3);
        chk("t4_no_en",  32'(seen), 32'd0);
        chk("t4_err",    32'(addr_err), 32'h1);
        repeat (5) step();
        chk("t4_sticky", 32'(addr_err), 32'h1);

        // Fetch withdrawn during ISSUE: no ack, outputs unchanged.
        fetch_addr = 16'h0005;
        fetch_req  = 1'b1;
        step();
        chk("t5_rom_en", 32'(rom_en), 32'h1);
        fetch_req = 1'b0;
        seen = 0;
        repeat (6) begin
            step();
            if (fetch_ack) seen = 1;
        end
        chk("t5_no_ack",  32'(seen), 32'd0);
        chk("t5_opcode",  32'(fetch_opcode), 32'hA5B5);
        chk("t5_operand", 32'(fetch_operand), 32'h1010);
        chk("t5_err",     32'(addr_err), 32'h1);

        // Reset asserted during CAPTURE: asynchronous clear, transaction dropped.
        data_addr = 16'h0020;
        data_req  = 1'b1;
        step();
        step();
        chk("t6_busy_pre", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy",  32'(busy), 32'h0);
        chk("t6_err",   32'(addr_err), 32'h0);
        chk("t6_dout",  32'(data_out), 32'h0);
        chk("t6_fop",   32'(fetch_opcode), 32'h0);
        chk("t6_raddr", 32'(rom_addr), 32'h0);
        data_req = 1'b0;
        #2;
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            step();
            if (data_ack || fetch_ack) seen = 1;
        end
        chk("t6_no_ack", 32'(seen), 32'd0);

        // Normal data read after reset.
        data_addr = 16'h0010;
        data_req  = 1'b1;
        lat = -1;
        for (int n = 1; n <= 10 && lat < 0; n++) begin
            step();
            if (data_ack) begin
                lat = n;
                chk("t7_dout", 32'(data_out), 32'h1010);
                data_req = 1'b0;
            end
        end
        data_req = 1'b0;
        chk("t7_cycle", 32'(lat), 32'd3);
        chk("t7_err",   32'(addr_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
